yen_mux_seq: RTL and testbench
==============================

YEN_MUX_SEQ -- requirements
Module: yen_mux_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, analog mux channel count (legal 2..8).
REQ-002 SHALL have parameter DWELL_W, default 8, width of the settle-time field.
REQ-003 SHALL have parameter BBM_CYC, default 2, break-before-make gap in clocks (legal 1..15).
REQ-004 SHALL derive CH_W = clog2(NUM_CH) internally.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 ena  in  1  block enable; low forces IDLE.
REQ-008 cmd_valid  in  1  channel-select request.
REQ-009 cmd_ch  in  CH_W  requested channel.
REQ-010 cmd_ready  out  1  request accepted when cmd_valid & cmd_ready.
REQ-011 dwell  in  DWELL_W  settle length, sampled at each MAKE entry.
REQ-012 scan_start  in  1  single-cycle pulse: start auto-scan.
REQ-013 scan_stop  in  1  single-cycle pulse: stop auto-scan.
REQ-014 sel_oh  out  NUM_CH  one-hot switch drive to analog mux macro, at most one bit set.
REQ-015 mux_en  out  1  high whenever any sel_oh bit is set.
REQ-016 cur_ch  out  CH_W  channel being driven or last held.
REQ-017 settled  out  1  high in HOLD.
REQ-018 busy  out  1  high in BREAK or SETTLE.
REQ-019 scan_active  out  1  auto-scan running.
REQ-020 err_ch  out  1  one-cycle pulse on rejected request.

Function
REQ-021 States SHALL be IDLE, BREAK, SETTLE, HOLD; sel_oh = 0 in IDLE and BREAK.
REQ-022 cmd_ready SHALL be high only in IDLE or HOLD, with scan_active = 0 and scan_start = 0.
REQ-023 Accepted request with cmd_ch < NUM_CH SHALL latch cur_ch and enter BREAK next cycle.
REQ-024 Request with cmd_ch >= NUM_CH SHALL be rejected: err_ch high next cycle for one cycle, state and outputs unchanged.
REQ-025 BREAK SHALL last exactly BBM_CYC cycles, then SETTLE.
REQ-026 SETTLE SHALL drive sel_oh = 1<<cur_ch for dwell+1 cycles (dwell = 0 gives 1 cycle), then HOLD.
REQ-027 Latency: accept in cycle T -> sel_oh valid from T+BBM_CYC+1; settled from T+BBM_CYC+dwell+2.
REQ-028 HOLD SHALL keep sel_oh until new request, ena low or scan advance.
REQ-029 Request for the channel already held SHALL still traverse BREAK and SETTLE.
REQ-030 ena = 0 SHALL force IDLE on the next edge, clearing sel_oh, mux_en, busy, settled and scan_active; cur_ch retained.
REQ-031 Requests arriving outside IDLE/HOLD SHALL be ignored, not queued.

Reset
REQ-032 rst_n low SHALL immediately clear all outputs and the state: IDLE, cur_ch = 0, sel_oh = 0.
REQ-033 Reset during SETTLE SHALL drop sel_oh asynchronously without waiting for a clock edge.
REQ-034 First post-reset action SHALL require a rising edge with rst_n high.

Configuration
REQ-035 Macro YEN_MUX_AUTOSCAN_EN SHALL compile auto-scan in.
REQ-036 With it defined: scan_start in IDLE/HOLD sets scan_active and selects channel 0 via BREAK/SETTLE; each HOLD lasts one cycle, then advances to (cur_ch+1) mod NUM_CH.
REQ-037 With it defined: scan_stop sets a stop flag; scan ends at the next HOLD, which is kept; scan_start and scan_stop in the same cycle means stop wins.
REQ-038 With it defined: scan_start coinciding with cmd_valid SHALL win, and the command is not accepted.
REQ-039 Without it: scan_start and scan_stop ignored, scan_active tied 0, ports still present.

Verification
REQ-040 NUM_CH=4, BBM_CYC=2, dwell=3, request ch2 accepted at cycle 0 -> sel_oh=0 cycles 1-2, sel_oh=4'b0100 cycles 3-6, settled=1 from cycle 7.
REQ-041 Holding ch2, request ch1 -> sel_oh=0 for exactly 2 cycles before 4'b0010; never two bits set.
REQ-042 Request cmd_ch=5 with NUM_CH=6 accepted; cmd_ch=6 with NUM_CH=6 -> err_ch one pulse, sel_oh unchanged.
REQ-043 rst_n low mid-SETTLE -> sel_oh=0 with no clock edge; after release state IDLE, cur_ch=0.
REQ-044 Macro defined, dwell=0, scan_start -> channels 0,1,2,3,0 cyclically; scan_stop during ch1 SETTLE -> stops in HOLD on ch1, scan_active=0.

Source files
------------

// File: rtl/yen_mux_seq.sv
`timescale 1ns/1ps
// yen_mux_seq
// Break-before-make sequencer for an external analog multiplexer macro.
// A channel request opens every switch for BBM_CYC clocks (BREAK), closes
// the requested switch and waits dwell+1 clocks for the signal to settle
// (SETTLE), then keeps the switch closed and flags the channel as usable
// (HOLD).
//
// Optional feature: define YEN_MUX_AUTOSCAN_EN to compile in auto-scan.
// Auto-scan visits channels 0,1,..,NUM_CH-1 and wraps. Each visit stays
// in HOLD for one cycle. Without the macro, scan_start and scan_stop are
// ignored and scan_active is tied low.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   ena          block enable; low returns to IDLE on the next edge
//   cmd_valid    channel-select request
//   cmd_ch       requested channel
//   cmd_ready    request accepted when cmd_valid & cmd_ready
//   dwell        settle length, sampled on entry to SETTLE
//   scan_start   single-cycle pulse that starts auto-scan
//   scan_stop    single-cycle pulse that stops auto-scan
//   sel_oh       one-hot switch drive; at most one bit set
//   mux_en       high whenever a switch is closed
//   cur_ch       channel being driven or last held
//   settled      high in HOLD
//   busy         high in BREAK or SETTLE
//   scan_active  auto-scan running
//   err_ch       one-cycle pulse after an out-of-range request
module yen_mux_seq #(
    parameter int NUM_CH  = 4,
    parameter int DWELL_W = 8,
    parameter int BBM_CYC = 2,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cmd_valid,
    input  logic [CH_W-1:0]    cmd_ch,
    output logic               cmd_ready,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               scan_start,
    input  logic               scan_stop,
    output logic [NUM_CH-1:0]  sel_oh,
    output logic               mux_en,
    output logic [CH_W-1:0]    cur_ch,
    output logic               settled,
    output logic               busy,
    output logic               scan_active,
    output logic               err_ch
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BREAK  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    // One counter serves both BREAK and SETTLE, so it must fit either.
    localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic            accept;
    logic            in_range;
    logic [CH_W-1:0] next_ch;

    assign in_range = (32'(cmd_ch) < 32'(NUM_CH));
    assign accept   = cmd_valid && cmd_ready;
    assign next_ch  = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);

`ifdef YEN_MUX_AUTOSCAN_EN
    logic scan_q;
    logic stop_flag;

    assign scan_active = scan_q;
    // A start pulse takes priority over a coincident command.
    assign cmd_ready = ena && ((state == IDLE) || (state == HOLD)) && !scan_q && !scan_start;
`else
    logic unused_scan;

    assign unused_scan = scan_start ^ scan_stop;
    assign scan_active = 1'b0;
    assign cmd_ready   = ena && ((state == IDLE) || (state == HOLD));
`endif

    // Outputs decode straight from the state register, so the async reset
    // opens the switch immediately with no clock edge needed.
    assign sel_oh  = ((state == SETTLE) || (state == HOLD)) ? (NUM_CH'(1) << cur_ch) : '0;
    assign mux_en  = |sel_oh;
    assign settled = (state == HOLD);
    assign busy    = (state == BREAK) || (state == SETTLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            cur_ch <= '0;
            err_ch <= 1'b0;
`ifdef YEN_MUX_AUTOSCAN_EN
            scan_q    <= 1'b0;
            stop_flag <= 1'b0;
`endif
        end else begin
            err_ch <= 1'b0;
            if (!ena) begin
                state <= IDLE;
`ifdef YEN_MUX_AUTOSCAN_EN
                scan_q    <= 1'b0;
                stop_flag <= 1'b0;
`endif
            end else begin
`ifdef YEN_MUX_AUTOSCAN_EN
                // Remember a stop request until the scan reaches HOLD.
                if (scan_q && scan_stop) begin
                    stop_flag <= 1'b1;
                end
`endif
                case (state)
                    IDLE, HOLD: begin
`ifdef YEN_MUX_AUTOSCAN_EN
                        if (scan_q) begin
                            if (stop_flag || scan_stop) begin
                                // Scan ends here; the current HOLD is kept.
                                scan_q    <= 1'b0;
                                stop_flag <= 1'b0;
                            end else begin
                                cur_ch <= next_ch;
                                cnt    <= CNT_W'(BBM_CYC - 1);
                                state  <= BREAK;
                            end
                        end else if (scan_start) begin
                            // Start and stop together: stop wins, nothing starts.
                            if (!scan_stop) begin
                                scan_q <= 1'b1;
                                cur_ch <= '0;
                                cnt    <= CNT_W'(BBM_CYC - 1);
                                state  <= BREAK;
                            end
                        end else
`endif
                        if (accept) begin
                            if (in_range) begin
                                cur_ch <= cmd_ch;
                                cnt    <= CNT_W'(BBM_CYC - 1);
                                state  <= BREAK;
                            end else begin
                                err_ch <= 1'b1;
                            end
                        end
                    end
                    BREAK: begin
                        if (cnt == '0) begin
                            cnt   <= CNT_W'(dwell);
                            state <= SETTLE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= HOLD;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_yen_mux_seq.sv
`timescale 1ns/1ps
module tb_yen_mux_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT with 4 channels (default parameters)
    logic       ena, cmd_valid, cmd_ready, scan_start, scan_stop;
    logic [1:0] cmd_ch, cur_ch;
    logic [7:0] dwell;
    logic [3:0] sel_oh;
    logic       mux_en, settled, busy, scan_active, err_ch;

    yen_mux_seq #(.NUM_CH(4), .DWELL_W(8), .BBM_CYC(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
        .cmd_ready(cmd_ready), .dwell(dwell), .scan_start(scan_start), .scan_stop(scan_stop),
        .sel_oh(sel_oh), .mux_en(mux_en), .cur_ch(cur_ch), .settled(settled), .busy(busy),
        .scan_active(scan_active), .err_ch(err_ch)
    );

    // DUT with 6 channels for the range check
    logic       ena6, v6, rdy6, sstart6, sstop6;
    logic [2:0] ch6, cur6;
    logic [7:0] dw6;
    logic [5:0] sel6;
    logic       mux6, set6, busy6, scan6, err6;

    yen_mux_seq #(.NUM_CH(6), .DWELL_W(8), .BBM_CYC(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .ena(ena6), .cmd_valid(v6), .cmd_ch(ch6),
        .cmd_ready(rdy6), .dwell(dw6), .scan_start(sstart6), .scan_stop(sstop6),
        .sel_oh(sel6), .mux_en(mux6), .cur_ch(cur6), .settled(set6), .busy(busy6),
        .scan_active(scan6), .err_ch(err6)
    );

    int nvec  = 0;
    int nfail = 0;

    typedef struct packed {
        logic       ena;
        logic       v;
        logic [1:0] ch;
        logic [7:0] dw;
        logic [3:0] sel;
        logic       st;
        logic       bsy;
        logic       rdy;
        logic [1:0] cur;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ena v ch dw  sel  st bsy rdy cur
        tbl[0]  = '{1'b1, 1'b1, 2'd2, 8'd3, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0}; // accept ch2
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2};
        tbl[2]  = '{1'b1, 1'b1, 2'd3, 8'd3, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2}; // ignored
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2};
        tbl[5]  = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd2};
        tbl[7]  = '{1'b1, 1'b1, 2'd1, 8'd0, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2}; // HOLD, ask ch1
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd1}; // dwell 0: 1 cycle
        tbl[11] = '{1'b1, 1'b1, 2'd1, 8'd0, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1}; // same channel again
        tbl[12] = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[14] = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd1};
        tbl[15] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd1}; // ena low in HOLD
        tbl[16] = '{1'b1, 1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[17] = '{1'b1, 1'b1, 2'd0, 8'd3, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1}; // accept ch0
        tbl[18] = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[19] = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[20] = '{1'b0, 1'b0, 2'd0, 8'd3, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0}; // ena low in SETTLE
        tbl[21] = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
        tbl[22] = '{1'b1, 1'b0, 2'd0, 8'd3, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};

        rst_n = 1'b0;
        ena = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; dwell = '0; scan_start = 1'b0; scan_stop = 1'b0;
        ena6 = 1'b1; v6 = 1'b0; ch6 = '0; dw6 = '0; sstart6 = 1'b0; sstop6 = 1'b0;
        #12;
        chk("reset4", {28'd0, sel_oh, mux_en, settled, busy, scan_active, err_ch, cur_ch},
            32'd0);
        chk("reset6", {26'd0, sel6, mux6, set6, busy6, scan6, err6, cur6}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven cycle trace on the 4-channel instance
        for (int i = 0; i < 23; i++) begin
            ena = tbl[i].ena; cmd_valid = tbl[i].v; cmd_ch = tbl[i].ch; dwell = tbl[i].dw;
            #1;
            chk($sformatf("vec%0d", i),
                {20'd0, sel_oh, mux_en, settled, busy, cmd_ready, err_ch, scan_active, cur_ch},
                {20'd0, tbl[i].sel, |tbl[i].sel, tbl[i].st, tbl[i].bsy, tbl[i].rdy, 1'b0, 1'b0,
                 tbl[i].cur});
            tick();
        end
        cmd_valid = 1'b0;

        // Range check on 6 channels: ch5 legal, ch6 rejected
        v6 = 1'b1; ch6 = 3'd5; dw6 = 8'd0;
        #1; chk("rdy6_idle", {31'd0, rdy6}, 32'd1);
        tick(); v6 = 1'b0;
        tick(); tick(); tick();
        chk("hold6_ch5", {24'd0, sel6, set6, cur6}, {24'd0, 6'b100000, 1'b1, 3'd5});
        v6 = 1'b1; ch6 = 3'd6;
        #1; chk("rdy6_hold", {31'd0, rdy6}, 32'd1);
        tick(); v6 = 1'b0;
        chk("err6_pulse", {23'd0, err6, sel6, set6, cur6}, {23'd0, 1'b1, 6'b100000, 1'b1, 3'd5});
        tick();
        chk("err6_end", {23'd0, err6, sel6, set6, busy6}, {23'd0, 1'b0, 6'b100000, 1'b1, 1'b0});

        // Asynchronous reset in the middle of SETTLE
        cmd_valid = 1'b1; cmd_ch = 2'd3; dwell = 8'd5;
        tick(); cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_settle", {27'd0, sel_oh, busy}, {27'd0, 4'b1000, 1'b1});
        #1; rst_n = 1'b0;
        #1;
        chk("async_rst", {24'd0, sel_oh, mux_en, busy, settled, cur_ch}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst", {24'd0, sel_oh, busy, settled, cmd_ready, cur_ch},
            {24'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0});

`ifdef YEN_MUX_AUTOSCAN_EN
        // Auto-scan: start beats a coincident command, channels wrap, stop keeps HOLD
        dwell = 8'd0; scan_start = 1'b1; cmd_valid = 1'b1; cmd_ch = 2'd3;
        #1; chk("scan_rdy_low", {31'd0, cmd_ready}, 32'd0);
        tick(); scan_start = 1'b0; cmd_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("scan_brk%0d", k), {27'd0, sel_oh, busy, scan_active, cur_ch},
                {27'd0, 4'b0000, 1'b1, 1'b1, 2'(k % 4)} >> 0);
            tick(); tick();
            if (k == 5) scan_stop = 1'b1;
            #1;
            chk($sformatf("scan_set%0d", k), {26'd0, sel_oh, busy, settled},
                {26'd0, 4'(1 << (k % 4)), 1'b1, 1'b0});
            tick(); scan_stop = 1'b0;
            chk($sformatf("scan_hold%0d", k), {26'd0, sel_oh, busy, settled},
                {26'd0, 4'(1 << (k % 4)), 1'b0, 1'b1});
            tick();
        end
        chk("scan_stopped", {24'd0, sel_oh, settled, scan_active, cmd_ready, cur_ch},
            {24'd0, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1});
        tick();
        chk("scan_stay", {24'd0, sel_oh, settled, scan_active, busy, cur_ch},
            {24'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd1});
`else
        // Without auto-scan the start pulse does nothing
        scan_start = 1'b1;
        #1; chk("noscan_rdy", {31'd0, cmd_ready}, 32'd1);
        tick(); scan_start = 1'b0;
        chk("noscan_idle", {29'd0, busy, scan_active, settled}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
